// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU function codes and the
// common data bus (CDB) bundle used by the issue unit, queues and ROB.
package cpu_pkg;

   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic              valid;
   } cdb_t;

endpackage

// File: rtl/issue_mul_pipe.sv
// MUL_LAT-stage pipelined multiplier. Stage 1 holds operands and tag,
// stage 2 forms the low DATA_W bits of the unsigned product, later stages
// shift it towards the CDB. The valid bits of the last two stages are
// exported so the parent can keep the ALU out of the multiplier's CDB slot.
module issue_mul_pipe #(
   parameter int MUL_LAT = 4,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              near_v,
   output logic              final_v,
   output logic [TAG_W-1:0]  final_tag,
   output logic [DATA_W-1:0] final_data
);
   import cpu_pkg::*;

   logic [MUL_LAT:1]  mv;
   logic [TAG_W-1:0]  tag_q  [1:MUL_LAT];
   logic [DATA_W-1:0] prod_q [2:MUL_LAT];
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   // Stage valid shift register; reset drops every in-flight multiply.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mv <= '0;
      end else begin
         mv <= {mv[MUL_LAT-1:1], in_valid};
      end
   end

   // Operand capture, product formation and tag/product shifting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_a <= '0;
         op_b <= '0;
         for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= '0;
         for (int k = 2; k <= MUL_LAT; k++) prod_q[k] <= '0;
      end else begin
         op_a     <= in_a;
         op_b     <= in_b;
         tag_q[1] <= in_tag;
         for (int k = 2; k <= MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
         prod_q[2] <= op_a * op_b;
         for (int k = 3; k <= MUL_LAT; k++) prod_q[k] <= prod_q[k-1];
      end
   end

   assign near_v     = mv[MUL_LAT-1];
   assign final_v    = mv[MUL_LAT];
   assign final_tag  = tag_q[MUL_LAT];
   assign final_data = prod_q[MUL_LAT];

endmodule

// File: rtl/issue_unit.sv
// Issue unit: accepts ready instructions from the integer and multiply
// queues, executes them on a 1-cycle ALU and a pipelined multiplier, and
// drives the single CDB with at most one result per cycle.
module issue_unit #(
   parameter int MUL_LAT = 4,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        issueint_opcode,
   input  logic [TAG_W-1:0]  issueint_rdtag,
   input  logic [DATA_W-1:0] issueint_rsdata,
   input  logic [DATA_W-1:0] issueint_rtdata,
   input  logic              issueint_ready,
   output logic              issueint_done,
   input  logic [TAG_W-1:0]  issuemul_rdtag,
   input  logic [DATA_W-1:0] issuemul_rsdata,
   input  logic [DATA_W-1:0] issuemul_rtdata,
   input  logic              issuemul_ready,
   output logic              issuemul_done,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_data,
   output logic              cdb_valid
);
   import cpu_pkg::*;

   logic              near_v;
   logic              final_v;
   logic [TAG_W-1:0]  mul_tag;
   logic [DATA_W-1:0] mul_data;
   logic              int_accept;
   logic              mul_accept;
   logic [DATA_W-1:0] alu_result;
   logic              alu_v_r;
   logic [TAG_W-1:0]  alu_tag_r;
   logic [DATA_W-1:0] alu_data_r;

   function automatic logic [DATA_W-1:0] alu_eval(input logic [5:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      case (op)
         FN_ADD, FN_ADDU: r = a + b;
         FN_SUB:          r = a - b;
         FN_AND:          r = a & b;
         FN_OR:           r = a | b;
         FN_XOR:          r = a ^ b;
         FN_NOR:          r = ~(a | b);
         FN_SLT:          r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         FN_SLTU:         r = {{(DATA_W-1){1'b0}}, (a < b)};
         default:         r = '0;
      endcase
      return r;
   endfunction

   issue_mul_pipe #(
      .MUL_LAT (MUL_LAT),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_mul (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (mul_accept),
      .in_tag     (issuemul_rdtag),
      .in_a       (issuemul_rsdata),
      .in_b       (issuemul_rtdata),
      .near_v     (near_v),
      .final_v    (final_v),
      .final_tag  (mul_tag),
      .final_data (mul_data)
   );

   // Same-cycle handshakes; the ALU is held off when a multiply will own the next CDB slot.
   always_comb begin
      int_accept = 1'b0;
      mul_accept = 1'b0;
      if (reset) begin
         mul_accept = issuemul_ready;
         int_accept = issueint_ready & ~near_v;
      end else begin
         mul_accept = 1'b0;
         int_accept = 1'b0;
      end
   end

   assign issueint_done = int_accept;
   assign issuemul_done = mul_accept;

   // Combinational ALU evaluation of the presented integer instruction.
   always_comb begin
      alu_result = alu_eval(issueint_opcode, issueint_rsdata, issueint_rtdata);
   end

   // ALU result register; holds zeros whenever no instruction was accepted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alu_v_r    <= 1'b0;
         alu_tag_r  <= '0;
         alu_data_r <= '0;
      end else begin
         alu_v_r    <= int_accept;
         alu_tag_r  <= int_accept ? issueint_rdtag : '0;
         alu_data_r <= int_accept ? alu_result : '0;
      end
   end

   // CDB mux: multiplier wins if both were ever valid; zeros when idle.
   always_comb begin
      cdb_valid = 1'b0;
      cdb_tag   = '0;
      cdb_data  = '0;
      if (final_v) begin
         cdb_valid = 1'b1;
         cdb_tag   = mul_tag;
         cdb_data  = mul_data;
      end else if (alu_v_r) begin
         cdb_valid = 1'b1;
         cdb_tag   = alu_tag_r;
         cdb_data  = alu_data_r;
      end else begin
         cdb_valid = 1'b0;
         cdb_tag   = '0;
         cdb_data  = '0;
      end
   end

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed vectors with literal expectations plus a
// cycle-indexed broadcast schedule model checked on every cycle.
module tb_issue_unit;
   localparam int ML = 4;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int NS = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    issueint_opcode;
   logic [TW-1:0] issueint_rdtag;
   logic [DW-1:0] issueint_rsdata;
   logic [DW-1:0] issueint_rtdata;
   logic          issueint_ready;
   logic          issueint_done;
   logic [TW-1:0] issuemul_rdtag;
   logic [DW-1:0] issuemul_rsdata;
   logic [DW-1:0] issuemul_rtdata;
   logic          issuemul_ready;
   logic          issuemul_done;
   logic [TW-1:0] cdb_tag;
   logic [DW-1:0] cdb_data;
   logic          cdb_valid;

   int n_chk = 0;
   int n_fail = 0;

   issue_unit #(.MUL_LAT(ML), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk             (clk),
      .reset           (reset),
      .issueint_opcode (issueint_opcode),
      .issueint_rdtag  (issueint_rdtag),
      .issueint_rsdata (issueint_rsdata),
      .issueint_rtdata (issueint_rtdata),
      .issueint_ready  (issueint_ready),
      .issueint_done   (issueint_done),
      .issuemul_rdtag  (issuemul_rdtag),
      .issuemul_rsdata (issuemul_rsdata),
      .issuemul_rtdata (issuemul_rtdata),
      .issuemul_ready  (issuemul_ready),
      .issuemul_done   (issuemul_done),
      .cdb_tag         (cdb_tag),
      .cdb_data        (cdb_data),
      .cdb_valid       (cdb_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'h20, 6'h21: return a + b;
         6'h22:        return a - b;
         6'h24:        return a & b;
         6'h25:        return a | b;
         6'h26:        return a ^ b;
         6'h27:        return ~(a | b);
         6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h2B:        return (a < b) ? 32'd1 : 32'd0;
         default:      return 32'd0;
      endcase
   endfunction

   // Model: a table of results expected on the CDB, indexed by cycle.
   logic          s_v    [0:NS-1];
   logic          s_mul  [0:NS-1];
   logic [TW-1:0] s_tag  [0:NS-1];
   logic [31:0]   s_data [0:NS-1];

   initial begin : cmp
      int   cyc;
      int   slot;
      int   tgt;
      logic exp_id;
      logic exp_md;
      for (int i = 0; i < NS; i++) begin
         s_v[i] = 1'b0; s_mul[i] = 1'b0; s_tag[i] = '0; s_data[i] = 32'd0;
      end
      cyc = 0;
      forever begin
         @(negedge clk);
         slot   = cyc % NS;
         exp_md = reset & issuemul_ready;
         exp_id = reset & issueint_ready & ~s_mul[(cyc + 1) % NS];
         check("m_mul_done", {31'd0, issuemul_done}, {31'd0, exp_md});
         check("m_int_done", {31'd0, issueint_done}, {31'd0, exp_id});
         check("m_cdb_valid", {31'd0, cdb_valid}, {31'd0, s_v[slot]});
         check("m_cdb_tag", {26'd0, cdb_tag}, s_v[slot] ? {26'd0, s_tag[slot]} : 32'd0);
         check("m_cdb_data", cdb_data, s_v[slot] ? s_data[slot] : 32'd0);
         s_v[slot] = 1'b0;
         s_mul[slot] = 1'b0;
         if (!reset) begin
            for (int i = 0; i < NS; i++) begin
               s_v[i] = 1'b0; s_mul[i] = 1'b0;
            end
         end else begin
            if (exp_md) begin
               tgt = (cyc + ML) % NS;
               s_v[tgt] = 1'b1; s_mul[tgt] = 1'b1;
               s_tag[tgt] = issuemul_rdtag;
               s_data[tgt] = issuemul_rsdata * issuemul_rtdata;
            end
            if (exp_id) begin
               tgt = (cyc + 1) % NS;
               s_v[tgt] = 1'b1;
               s_tag[tgt] = issueint_rdtag;
               s_data[tgt] = ref_alu(issueint_opcode, issueint_rsdata, issueint_rtdata);
            end
         end
         cyc++;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic alu_one(input string nm, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tg, input logic [31:0] exp);
      nxt();
      issueint_opcode = op; issueint_rsdata = a; issueint_rtdata = b;
      issueint_rdtag = tg; issueint_ready = 1'b1;
      smp();
      check({nm, "_done"}, {31'd0, issueint_done}, 32'd1);
      nxt();
      issueint_ready = 1'b0;
      smp();
      check({nm, "_valid"}, {31'd0, cdb_valid}, 32'd1);
      check({nm, "_tag"}, {26'd0, cdb_tag}, {26'd0, tg});
      check({nm, "_data"}, cdb_data, exp);
   endtask

   initial begin : drv
      logic [5:0] ops [0:8];
      logic [5:0] vec;
      logic [5:0] exp_done;
      logic [5:0] tag_int;
      ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h22; ops[3] = 6'h24; ops[4] = 6'h25;
      ops[5] = 6'h26; ops[6] = 6'h27; ops[7] = 6'h2A; ops[8] = 6'h2B;

      // Reset with both queues ready.
      reset = 1'b0;
      issueint_opcode = 6'h20; issueint_rsdata = 32'd1; issueint_rtdata = 32'd2;
      issueint_rdtag = 6'd1; issueint_ready = 1'b1;
      issuemul_rsdata = 32'd2; issuemul_rtdata = 32'd3; issuemul_rdtag = 6'd2;
      issuemul_ready = 1'b1;
      repeat (3) begin
         nxt();
         smp();
         check("rst_int_done", {31'd0, issueint_done}, 32'd0);
         check("rst_mul_done", {31'd0, issuemul_done}, 32'd0);
         check("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
      end
      nxt();
      reset = 1'b1;
      smp();
      check("rel_int_done", {31'd0, issueint_done}, 32'd1);
      check("rel_mul_done", {31'd0, issuemul_done}, 32'd1);
      nxt();
      issueint_ready = 1'b0; issuemul_ready = 1'b0;
      smp();
      check("rel_cdb_tag", {26'd0, cdb_tag}, 32'd1);
      check("rel_cdb_data", cdb_data, 32'd3);
      repeat (6) nxt();

      // ALU directed vectors.
      alu_one("add",  6'h20, 32'd5, 32'd7, 6'd12, 32'd12);
      alu_one("slt",  6'h2A, 32'hFFFF_FFFF, 32'd0, 6'd13, 32'd1);
      alu_one("sltu", 6'h2B, 32'hFFFF_FFFF, 32'd0, 6'd14, 32'd0);
      alu_one("sub",  6'h22, 32'd3, 32'd5, 6'd15, 32'hFFFF_FFFE);
      alu_one("nor",  6'h27, 32'h0F0F_0F0F, 32'hF0F0_0000, 6'd16, 32'h0000_F0F0);
      alu_one("addw", 6'h20, 32'hFFFF_FFFF, 32'd1, 6'd17, 32'd0);
      alu_one("ill",  6'h3F, 32'd5, 32'd5, 6'd18, 32'd0);

      // Back-to-back ALU ops, checked by the model.
      for (int i = 0; i < 9; i++) begin
         nxt();
         issueint_opcode = ops[i];
         issueint_rsdata = 32'h8000_0003 + 32'(i * 7);
         issueint_rtdata = 32'h0000_1235 - 32'(i * 3);
         issueint_rdtag = 6'(20 + i);
         issueint_ready = 1'b1;
      end
      nxt();
      issueint_ready = 1'b0;
      repeat (3) nxt();

      // Multiply latency.
      issuemul_rsdata = 32'd6; issuemul_rtdata = 32'd9; issuemul_rdtag = 6'd33;
      issuemul_ready = 1'b1;
      smp();
      check("mul_done", {31'd0, issuemul_done}, 32'd1);
      for (int i = 1; i < ML; i++) begin
         nxt();
         issuemul_ready = 1'b0;
         smp();
         check("mul_early", {31'd0, cdb_valid}, 32'd0);
      end
      nxt();
      smp();
      check("mul_valid", {31'd0, cdb_valid}, 32'd1);
      check("mul_tag", {26'd0, cdb_tag}, 32'd33);
      check("mul_data", cdb_data, 32'd54);
      repeat (2) nxt();

      // Four back-to-back multiplies.
      for (int i = 0; i < 4; i++) begin
         issuemul_ready = 1'b1; issuemul_rdtag = 6'(40 + i);
         issuemul_rsdata = 32'(i + 2); issuemul_rtdata = 32'd3;
         nxt();
      end
      issuemul_ready = 1'b0;
      vec = 6'd0;
      for (int j = 0; j < 6; j++) begin
         smp();
         vec[j] = cdb_valid;
         if (j == 0) check("b2b_first_data", cdb_data, 32'd6);
         nxt();
      end
      check("b2b_pattern", {26'd0, vec}, 32'h0000_000F);
      repeat (2) nxt();

      // Collision block plus simultaneous accept.
      exp_done = 6'b110111;
      tag_int = 6'd20;
      issuemul_ready = 1'b1; issuemul_rdtag = 6'd50;
      issuemul_rsdata = 32'd3; issuemul_rtdata = 32'd4;
      issueint_opcode = 6'h20; issueint_rsdata = 32'd1; issueint_rtdata = 32'd1;
      issueint_rdtag = tag_int; issueint_ready = 1'b1;
      smp();
      check("sim_int_done", {31'd0, issueint_done}, 32'd1);
      check("sim_mul_done", {31'd0, issuemul_done}, 32'd1);
      for (int i = 1; i < 6; i++) begin
         nxt();
         issuemul_ready = 1'b0;
         if (exp_done[i-1]) tag_int = tag_int + 6'd1;
         issueint_rdtag = tag_int;
         smp();
         check("blk_int_done", {31'd0, issueint_done}, {31'd0, exp_done[i]});
         if (i == 4) begin
            check("blk_mul_tag", {26'd0, cdb_tag}, 32'd50);
            check("blk_mul_data", cdb_data, 32'd12);
         end
         if (i == 5) check("blk_alu_tag", {26'd0, cdb_tag}, 32'd23);
      end
      nxt();
      issueint_ready = 1'b0;
      smp();
      check("blk_last_tag", {26'd0, cdb_tag}, 32'd24);
      repeat (6) nxt();

      // Reset while a multiply is in flight.
      issuemul_ready = 1'b1; issuemul_rdtag = 6'd60;
      issuemul_rsdata = 32'd7; issuemul_rtdata = 32'd7;
      nxt();
      issuemul_ready = 1'b0;
      nxt();
      reset = 1'b0; issueint_ready = 1'b1;
      smp();
      check("mrst_int_done", {31'd0, issueint_done}, 32'd0);
      nxt();
      reset = 1'b1; issueint_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp();
         check("mrst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
         nxt();
      end

      repeat (3) nxt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
